// File: rtl/ex_muldiv_if.sv
// EX-stage mul/div operand and result bundle.
// The ID/EX side drives operands; the unit answers with stall and result.
interface ex_muldiv_if;
    logic [4:0]  ALUOp;
    logic        ALUSrc;
    logic [31:0] registerFileDataA;
    logic [31:0] registerFileDataB;
    logic [31:0] extendedSignal;
    logic        flush;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic        div_by_zero;

    modport master (
        output ALUOp, ALUSrc, registerFileDataA,
        output registerFileDataB, extendedSignal, flush,
        input  stall, result, result_valid, div_by_zero
    );

    modport slave (
        input  ALUOp, ALUSrc, registerFileDataA,
        input  registerFileDataB, extendedSignal, flush,
        output stall, result, result_valid, div_by_zero
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply/divide for the EX stage.
// Shift-add multiply and restoring divide, one bit per negedge.
module ex_muldiv #(
    parameter logic [4:0] OP_MUL   = 5'd16,
    parameter logic [4:0] OP_MULHU = 5'd17,
    parameter logic [4:0] OP_DIVU  = 5'd18,
    parameter logic [4:0] OP_REMU  = 5'd19
) (
    input logic       clock,
    input logic       reset_n,
    ex_muldiv_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  count;
    logic [4:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] prod;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] result_q;
    logic        dbz_q;

    logic [31:0] op_b;
    logic        is_md;
    logic        is_mul_in;
    logic        start;
    logic        last;
    logic [32:0] sum;
    logic [63:0] prod_next;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] rem_next;
    logic [31:0] quo_next;

    always_comb begin
        op_b = bus.ALUSrc ? bus.extendedSignal
                          : bus.registerFileDataB;
        is_md = bus.ALUOp inside
                {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
        is_mul_in = (bus.ALUOp == OP_MUL) ||
                    (bus.ALUOp == OP_MULHU);
        start = is_md && !bus.flush;
        last = (count == 5'd31);
        sum = {1'b0, prod[63:32]} +
              {1'b0, (prod[0] ? a_q : 32'h0)};
        prod_next = {sum, prod[31:1]};
        // remainder stays below the divisor, so 32 bits hold it
        shifted = {1'b0, rem, quo[31]};
        ge = (shifted >= {1'b0, b_q});
        rem_next = ge ? (shifted[31:0] - b_q) : shifted[31:0];
        quo_next = {quo[30:0], ge};
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (is_mul_in) begin
                        state_next = S_MUL;
                    end else if (op_b == 32'h0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_DIV;
                    end
                end
            end
            S_MUL:  if (last) state_next = S_DONE;
            S_DIV:  if (last) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (bus.flush) state_next = S_IDLE;
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= 5'd0;
            op_q     <= 5'd0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            prod     <= 64'h0;
            rem      <= 32'h0;
            quo      <= 32'h0;
            result_q <= 32'h0;
            dbz_q    <= 1'b0;
        end else if (bus.flush) begin
            count <= 5'd0;
            dbz_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        count <= 5'd0;
                        op_q  <= bus.ALUOp;
                        a_q   <= bus.registerFileDataA;
                        b_q   <= op_b;
                        prod  <= {32'h0, op_b};
                        rem   <= 32'h0;
                        quo   <= bus.registerFileDataA;
                        if (!is_mul_in && op_b == 32'h0) begin
                            result_q <= (bus.ALUOp == OP_DIVU)
                                ? 32'hFFFF_FFFF
                                : bus.registerFileDataA;
                            dbz_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    prod  <= prod_next;
                    count <= count + 5'd1;
                    if (last) begin
                        result_q <= (op_q == OP_MULHU)
                            ? prod_next[63:32]
                            : prod_next[31:0];
                    end
                end
                S_DIV: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 5'd1;
                    if (last) begin
                        result_q <= (op_q == OP_REMU)
                            ? rem_next : quo_next;
                    end
                end
                S_DONE: begin
                    count <= 5'd0;
                    dbz_q <= 1'b0;
                end
                default: count <= 5'd0;
            endcase
        end
    end

    // reset also silences the combinational stall
    assign bus.stall = reset_n && !bus.flush && is_md &&
                       (state != S_DONE);
    assign bus.result       = result_q;
    assign bus.result_valid = (state == S_DONE);
    assign bus.div_by_zero  = dbz_q;
endmodule
